// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared types, geometry, colours and LCD opcodes for the tile writer
package tile_pkg;

  localparam int TILE_PX = 20;
  localparam logic [3:0] TILE_ROWS = 4'd12;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_PASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    OBJ_EMPTY  = 3'd0,
    OBJ_BORDER = 3'd1,
    OBJ_HEAD   = 3'd2,
    OBJ_BODY   = 3'd3,
    OBJ_APPLE  = 3'd4
  } obj_code_t;

  localparam logic [15:0] COL_EMPTY  = 16'h0000;
  localparam logic [15:0] COL_BORDER = 16'h7BEF;
  localparam logic [15:0] COL_HEAD   = 16'h07E0;
  localparam logic [15:0] COL_BODY   = 16'h03E0;
  localparam logic [15:0] COL_APPLE  = 16'hF800;
  localparam logic [15:0] COL_OTHER  = 16'hF81F;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CASET, ST_CA_PARAM, ST_PASET,
    ST_PA_PARAM, ST_RAMWR, ST_PIXELS, ST_DONE
  } state_t;

  // Codes beyond APPLE are unassigned and drawn magenta so they stand out on the panel
  function automatic logic [15:0] colour_of(input logic [2:0] code);
    case (code)
      OBJ_EMPTY:  return COL_EMPTY;
      OBJ_BORDER: return COL_BORDER;
      OBJ_HEAD:   return COL_HEAD;
      OBJ_BODY:   return COL_BODY;
      OBJ_APPLE:  return COL_APPLE;
      default:    return COL_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// rtl/lcd_byte_writer.sv - two-phase 8080-style byte strobe with valid/ready handshake
module lcd_byte_writer (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  input  logic       byte_dc,
  output logic       byte_ready,
  output logic       lcd_csx,
  output logic       lcd_dcx,
  output logic       lcd_wrx,
  output logic [7:0] lcd_data
);

  // Ready in phase B so back-to-back bytes stream with no idle cycle
  assign byte_ready = lcd_wrx;

  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_csx  <= 1'b1;
      lcd_wrx  <= 1'b1;
      lcd_dcx  <= 1'b1;
      lcd_data <= 8'h00;
    end else if (byte_valid && byte_ready) begin
      lcd_csx  <= 1'b0;
      lcd_wrx  <= 1'b0;
      lcd_dcx  <= byte_dc;
      lcd_data <= byte_data;
    end else if (!lcd_wrx) begin
      lcd_wrx <= 1'b1;
    end else begin
      lcd_csx <= 1'b1;
    end
  end

endmodule

// File: rtl/tile_lcd_writer.sv
// rtl/tile_lcd_writer.sv - draws one solid-colour tile on a parallel-bus LCD
module tile_lcd_writer
  import tile_pkg::*;
#(
  parameter int TILE_PX = tile_pkg::TILE_PX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tile_valid,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [2:0] obj_code,
  output logic       busy,
  output logic       cmd_done,
  output logic       lcd_csx,
  output logic       lcd_dcx,
  output logic       lcd_wrx,
  output logic [7:0] lcd_data
);

  localparam logic [9:0] PIX_LAST = 10'(2 * TILE_PX * TILE_PX - 1);

  state_t      state, nxt_state;
  logic [1:0]  param_idx, nxt_pidx;
  logic [9:0]  pix_cnt, nxt_pcnt;
  logic [3:0]  x_q, y_q;
  logic [2:0]  obj_q;
  logic [8:0]  xs, xe;
  logic [7:0]  ys, ye;
  logic [15:0] colour;
  logic [7:0]  ca_bytes [4];
  logic [7:0]  pa_bytes [4];
  logic        byte_valid, byte_dc, byte_ready;
  logic [7:0]  byte_data;

  assign xs     = 9'(x_q * TILE_PX);
  assign xe     = xs + 9'(TILE_PX - 1);
  assign ys     = 8'(y_q * TILE_PX);
  assign ye     = ys + 8'(TILE_PX - 1);
  assign colour = colour_of(obj_q);

  always_comb begin
    ca_bytes[0] = {7'd0, xs[8]};
    ca_bytes[1] = xs[7:0];
    ca_bytes[2] = {7'd0, xe[8]};
    ca_bytes[3] = xe[7:0];
    pa_bytes[0] = 8'h00;
    pa_bytes[1] = ys;
    pa_bytes[2] = 8'h00;
    pa_bytes[3] = ye;
  end

  // State names the byte currently on the bus; this decodes the byte to offer next
  always_comb begin
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    byte_dc    = 1'b1;
    nxt_state  = state;
    nxt_pidx   = param_idx;
    nxt_pcnt   = pix_cnt;
    case (state)
      ST_IDLE: begin
        if (tile_valid) begin
          if (y < TILE_ROWS) begin
            byte_valid = 1'b1;
            byte_data  = CMD_CASET;
            byte_dc    = 1'b0;
            nxt_state  = ST_CASET;
          end else begin
            nxt_state = ST_DONE;
          end
        end
      end
      ST_CASET: begin
        byte_valid = 1'b1;
        byte_data  = ca_bytes[0];
        nxt_state  = ST_CA_PARAM;
        nxt_pidx   = 2'd0;
      end
      ST_CA_PARAM: begin
        byte_valid = 1'b1;
        if (param_idx == 2'd3) begin
          byte_data = CMD_PASET;
          byte_dc   = 1'b0;
          nxt_state = ST_PASET;
        end else begin
          nxt_pidx  = param_idx + 2'd1;
          byte_data = ca_bytes[nxt_pidx];
        end
      end
      ST_PASET: begin
        byte_valid = 1'b1;
        byte_data  = pa_bytes[0];
        nxt_state  = ST_PA_PARAM;
        nxt_pidx   = 2'd0;
      end
      ST_PA_PARAM: begin
        byte_valid = 1'b1;
        if (param_idx == 2'd3) begin
          byte_data = CMD_RAMWR;
          byte_dc   = 1'b0;
          nxt_state = ST_RAMWR;
        end else begin
          nxt_pidx  = param_idx + 2'd1;
          byte_data = pa_bytes[nxt_pidx];
        end
      end
      ST_RAMWR: begin
        byte_valid = 1'b1;
        byte_data  = colour[15:8];
        nxt_state  = ST_PIXELS;
        nxt_pcnt   = 10'd0;
      end
      ST_PIXELS: begin
        if (pix_cnt == PIX_LAST) begin
          nxt_state = ST_DONE;
        end else begin
          byte_valid = 1'b1;
          nxt_pcnt   = pix_cnt + 10'd1;
          byte_data  = pix_cnt[0] ? colour[15:8] : colour[7:0];
        end
      end
      ST_DONE: nxt_state = ST_IDLE;
    endcase
  end

  // Every transition waits on the writer; it is always ready in IDLE and DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      cmd_done  <= 1'b0;
      param_idx <= 2'd0;
      pix_cnt   <= 10'd0;
      x_q       <= 4'd0;
      y_q       <= 4'd0;
      obj_q     <= 3'd0;
    end else if (byte_ready) begin
      state     <= nxt_state;
      param_idx <= nxt_pidx;
      pix_cnt   <= nxt_pcnt;
      busy      <= (nxt_state != ST_IDLE) && (nxt_state != ST_DONE);
      cmd_done  <= (nxt_state == ST_DONE);
      if (state == ST_IDLE && tile_valid) begin
        x_q   <= x;
        y_q   <= y;
        obj_q <= obj_code;
      end
    end
  end

  lcd_byte_writer u_byte_writer (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc),
    .byte_ready (byte_ready),
    .lcd_csx    (lcd_csx),
    .lcd_dcx    (lcd_dcx),
    .lcd_wrx    (lcd_wrx),
    .lcd_data   (lcd_data)
  );

endmodule

// File: tb/tb_tile_lcd_writer.sv
// tb/tb_tile_lcd_writer.sv - scoreboard bench for tile_lcd_writer
module tb_tile_lcd_writer;

  localparam int TPX = 20;

  logic       tb_clk = 1'b0;
  logic       rst = 1'b1;
  logic       tile_valid = 1'b0;
  logic [3:0] x = 4'd0;
  logic [3:0] y = 4'd0;
  logic [2:0] obj_code = 3'd0;
  logic       busy, cmd_done, lcd_csx, lcd_dcx, lcd_wrx;
  logic [7:0] lcd_data;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  logic [8:0] exp_q [$];
  int done_q [$];
  int act_lo = 0;
  int act_hi = -1;
  int done_cyc = -10;
  bit mon_en = 1'b0;
  logic prev_wrx = 1'b1;
  logic [8:0] last_bus = 9'd0;
  logic [15:0] colours [8] = '{16'h0000, 16'h7BEF, 16'h07E0, 16'h03E0,
                               16'hF800, 16'hF81F, 16'hF81F, 16'hF81F};

  tile_lcd_writer dut (
    .clk        (tb_clk),
    .rst        (rst),
    .tile_valid (tile_valid),
    .x          (x),
    .y          (y),
    .obj_code   (obj_code),
    .busy       (busy),
    .cmd_done   (cmd_done),
    .lcd_csx    (lcd_csx),
    .lcd_dcx    (lcd_dcx),
    .lcd_wrx    (lcd_wrx),
    .lcd_data   (lcd_data)
  );

  always #5 tb_clk = ~tb_clk;
  always @(posedge tb_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: DUT activity seen, expected none (cycle %0d)", name, cyc);
  endtask

  task automatic push_word(input int v);
    exp_q.push_back({1'b1, 8'((v >> 8) & 255)});
    exp_q.push_back({1'b1, 8'(v & 255)});
  endtask

  // Reference: a request is taken only if the block is idle; emit the whole byte stream it implies
  task automatic model_tile(input int tx, input int ty, input int tc);
    int xs, ys;
    if (cyc < done_cyc + 2) return;
    if (ty < 12) begin
      xs = tx * TPX;
      ys = ty * TPX;
      exp_q.push_back({1'b0, 8'h2A});
      push_word(xs);
      push_word(xs + TPX - 1);
      exp_q.push_back({1'b0, 8'h2B});
      push_word(ys);
      push_word(ys + TPX - 1);
      exp_q.push_back({1'b0, 8'h2C});
      for (int i = 0; i < TPX * TPX; i++) push_word(int'(colours[tc]));
      act_lo = cyc;
      act_hi = cyc + 2 * (11 + 2 * TPX * TPX) - 1;
      done_cyc = act_hi + 1;
    end else begin
      done_cyc = cyc;
    end
    done_q.push_back(done_cyc);
  endtask

  task automatic send_tile(input int tx, input int ty, input int tc, output int n);
    @(posedge tb_clk); #1;
    tile_valid = 1'b1;
    x = 4'(tx);
    y = 4'(ty);
    obj_code = 3'(tc);
    @(posedge tb_clk); #1;
    tile_valid = 1'b0;
    n = cyc;
    model_tile(tx, ty, tc);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge tb_clk); #1;
    end
  endtask

  task automatic apply_reset(input int ncyc, input bit with_req);
    @(posedge tb_clk); #1;
    rst = 1'b1;
    tile_valid = with_req;
    x = 4'd1;
    y = 4'd1;
    obj_code = 3'd1;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge tb_clk); #1;
      exp_q.delete();
      done_q.delete();
      act_hi = -1;
      done_cyc = cyc - 2;
      check("rst_csx", lcd_csx, 1);
      check("rst_wrx", lcd_wrx, 1);
      check("rst_dcx", lcd_dcx, 1);
      check("rst_data", lcd_data, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_done", cmd_done, 0);
    end
    rst = 1'b0;
    tile_valid = 1'b0;
  endtask

  always @(negedge tb_clk) begin
    bit act;
    if (mon_en) begin
      act = (cyc >= act_lo) && (cyc <= act_hi);
      check("busy", busy, act);
      check("csx", lcd_csx, !act);
      if (!lcd_wrx && prev_wrx) begin
        if (exp_q.size() == 0) fail("unexpected_byte");
        else check("bus_byte", {lcd_dcx, lcd_data}, exp_q.pop_front());
        last_bus = {lcd_dcx, lcd_data};
      end else if (lcd_wrx && !prev_wrx && act) begin
        check("phase_b_hold", {lcd_dcx, lcd_data}, last_bus);
      end
      prev_wrx = lcd_wrx;
      if (cmd_done || (done_q.size() > 0 && done_q[0] == cyc)) begin
        if (done_q.size() == 0) fail("cmd_done_unexpected");
        else check("cmd_done_cycle", cmd_done ? cyc : -1, done_q.pop_front());
      end
    end
  end

  initial begin
    int n, m, tx, ty, tc;
    apply_reset(2, 1'b0);
    mon_en = 1'b1;

    send_tile(0, 0, 1, n);
    wait_until(done_cyc + 1);
    send_tile(15, 11, 4, n);
    wait_until(done_cyc + 1);

    send_tile(3, 6, 3, n);
    wait_until(n + 98);
    send_tile(4, 4, 0, m);
    wait_until(done_cyc + 1);

    send_tile(5, 12, 1, n);
    wait_until(done_cyc + 1);

    send_tile(9, 2, 4, n);
    wait_until(n + 621);
    apply_reset(2, 1'b1);
    send_tile(7, 4, 2, n);
    wait_until(done_cyc + 1);

    for (int t = 0; t < 4; t++) begin
      tx = $urandom_range(15);
      ty = $urandom_range(11);
      tc = $urandom_range(7);
      send_tile(tx, ty, tc, n);
      if ($urandom_range(1) == 1) begin
        wait_until(n + $urandom_range(1500, 1));
        send_tile($urandom_range(15), $urandom_range(13), $urandom_range(7), m);
      end
      wait_until(done_cyc + 1);
    end

    repeat (4) @(posedge tb_clk);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    check("done_q_drained", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
